// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - control codes, FSM states and decode helpers for the multicycle ALU
//
// Contents:
//   OP_*                  5-bit ALU control codes 0..19
//   OP_PRIMEIRO_INVALIDO  first unsupported code; 20..31 (31 = no-op) raise erro
//   estado_t              FSM state encoding (ST_IDLE / ST_MULT / ST_DIV)
//   eh_divisao()          true for the codes served by the restoring divider

package ula_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_NOT  = 5'd4;
  localparam logic [4:0] OP_SHL  = 5'd5;
  localparam logic [4:0] OP_SHR  = 5'd6;
  localparam logic [4:0] OP_BEQ  = 5'd7;
  localparam logic [4:0] OP_BNEQ = 5'd8;
  localparam logic [4:0] OP_BLZ  = 5'd9;
  localparam logic [4:0] OP_SLT  = 5'd10;
  localparam logic [4:0] OP_SGT  = 5'd11;
  localparam logic [4:0] OP_MULT = 5'd12;
  localparam logic [4:0] OP_DIV  = 5'd13;
  localparam logic [4:0] OP_MOD  = 5'd14;
  localparam logic [4:0] OP_XOR  = 5'd15;
  localparam logic [4:0] OP_NAND = 5'd16;
  localparam logic [4:0] OP_NOR  = 5'd17;
  localparam logic [4:0] OP_BLT  = 5'd18;
  localparam logic [4:0] OP_BGRT = 5'd19;

  localparam logic [4:0] OP_PRIMEIRO_INVALIDO = 5'd20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } estado_t;

  function automatic logic eh_divisao(input logic [4:0] c);
    return (c == OP_DIV) || (c == OP_MOD);
  endfunction

endpackage

// File: rtl/ula_divisor.sv
// rtl/ula_divisor.sv - restoring divider datapath, one quotient bit per step
//
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   carrega         load dividendo/divisor and clear the partial remainder
//   passo           perform one restoring iteration (counter lives in the caller)
//   dividendo       unsigned dividend
//   divisor         unsigned divisor
//   quociente_prox  quotient after the iteration currently in progress
//   resto_prox      remainder after the iteration currently in progress
//
// The caller captures the *_prox values on the final iteration edge, so the
// result is available with no extra cycle. With divisor==0 every trial
// subtraction succeeds: the quotient fills with ones and the remainder
// collects the dividend, which is exactly the required b==0 result.

module ula_divisor #(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carrega,
  input  logic               passo,
  input  logic [LARGURA-1:0] dividendo,
  input  logic [LARGURA-1:0] divisor,
  output logic [LARGURA-1:0] quociente_prox,
  output logic [LARGURA-1:0] resto_prox
);

  logic [LARGURA-1:0] quoc;
  logic [LARGURA-1:0] resto;
  logic [LARGURA-1:0] div_reg;
  logic [LARGURA:0]   parcial;
  logic [LARGURA+1:0] dif;

  // quoc doubles as the dividend shift register: its MSB feeds the remainder
  // while quotient bits enter at the bottom.
  always_comb begin
    parcial = {resto, quoc[LARGURA-1]};
    dif     = {1'b0, parcial} - {2'b00, div_reg};
    if (dif[LARGURA+1]) begin
      resto_prox     = parcial[LARGURA-1:0];
      quociente_prox = {quoc[LARGURA-2:0], 1'b0};
    end else begin
      resto_prox     = dif[LARGURA-1:0];
      quociente_prox = {quoc[LARGURA-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      quoc    <= '0;
      resto   <= '0;
      div_reg <= '0;
    end else if (carrega) begin
      quoc    <= dividendo;
      resto   <= '0;
      div_reg <= divisor;
    end else if (passo) begin
      quoc    <= quociente_prox;
      resto   <= resto_prox;
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - multicycle execute-stage ALU with iterative mult/div/mod
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   start          launch an operation (ignored while busy)
//   controle       5-bit ALU control code
//   a, b           operands; b[4:0] is the shift amount for shl/shr
//   busy           iterative operation in progress
//   done           one-cycle pulse, resultado and flags valid
//   resultado      registered result, held until the next done
//   zero           resultado == 0
//   desvio         branch condition (branch codes only)
//   div_zero       div/mod with b == 0
//   erro           unsupported control code (20..31)
//
// Build option: MULT_FAST_EN selects a combinational single-cycle multiplier;
// otherwise mult is an iterative shift-add taking LARGURA cycles.

module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         controle,
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [LARGURA-1:0] resultado,
  output logic               zero,
  output logic               desvio,
  output logic               div_zero,
  output logic               erro
);

  localparam int CW = $clog2(LARGURA);

  estado_t            estado, prox_estado;
  logic [CW-1:0]      cnt;
  logic [LARGURA-1:0] b_reg;
  logic               mod_reg;
  logic               aceita, iterativo, mult_iter, ultimo, fim_iter;
  logic [LARGURA-1:0] r_simples, r_iter;
  logic               d_simples, e_simples;
  logic [LARGURA-1:0] quoc_prox, resto_prox, mult_prox;
  logic               menor, maior;

  assign aceita    = start && (estado == ST_IDLE);
  assign iterativo = mult_iter || eh_divisao(controle);
  assign ultimo    = (cnt == CW'(LARGURA - 1));

  // ---------------- multiplier ----------------
`ifdef MULT_FAST_EN
  assign mult_iter = 1'b0;
  assign mult_prox = '0;
`else
  logic [LARGURA-1:0] acc, mcand, mplier;

  assign mult_iter = (controle == OP_MULT);
  assign mult_prox = acc + (mplier[0] ? mcand : '0);

  // Shift-add: only the low LARGURA bits of the product are kept, so the
  // shifted multiplicand may simply drop bits off the top.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (aceita) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (estado == ST_MULT) begin
      acc    <= mult_prox;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`endif

  // ---------------- divider ----------------
  ula_divisor #(.LARGURA(LARGURA)) u_divisor (
    .clock          (clock),
    .reset          (reset),
    .carrega        (aceita && eh_divisao(controle)),
    .passo          (estado == ST_DIV),
    .dividendo      (a),
    .divisor        (b),
    .quociente_prox (quoc_prox),
    .resto_prox     (resto_prox)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (reset) estado <= ST_IDLE;
    else       estado <= prox_estado;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    prox_estado = estado;
    case (estado)
      ST_IDLE: begin
        if (aceita && mult_iter)                  prox_estado = ST_MULT;
        else if (aceita && eh_divisao(controle))  prox_estado = ST_DIV;
      end
      ST_MULT, ST_DIV: begin
        if (ultimo) prox_estado = ST_IDLE;
      end
      default: prox_estado = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy     = (estado != ST_IDLE);
    fim_iter = busy && ultimo;
    if (estado == ST_MULT) r_iter = mult_prox;
    else if (mod_reg)      r_iter = resto_prox;
    else                   r_iter = quoc_prox;
  end

  // ---------------- single-cycle operations ----------------
  assign menor = ($signed(a) < $signed(b));
  assign maior = ($signed(a) > $signed(b));

  always_comb begin
    r_simples = '0;
    d_simples = 1'b0;
    e_simples = (controle >= OP_PRIMEIRO_INVALIDO);
    case (controle)
      OP_ADD:  r_simples = a + b;
      OP_SUB:  r_simples = a - b;
      OP_AND:  r_simples = a & b;
      OP_OR:   r_simples = a | b;
      OP_NOT:  r_simples = ~a;
      OP_SHL:  r_simples = a << b[4:0];
      OP_SHR:  r_simples = a >> b[4:0];
      OP_BEQ:  begin r_simples = a - b; d_simples = (a == b);     end
      OP_BNEQ: begin r_simples = a - b; d_simples = (a != b);     end
      OP_BLZ:  begin r_simples = a - b; d_simples = a[LARGURA-1]; end
      OP_BLT:  begin r_simples = a - b; d_simples = menor;        end
      OP_BGRT: begin r_simples = a - b; d_simples = maior;        end
      OP_SLT:  r_simples = {{(LARGURA-1){1'b0}}, menor};
      OP_SGT:  r_simples = {{(LARGURA-1){1'b0}}, maior};
`ifdef MULT_FAST_EN
      OP_MULT: r_simples = a * b;
`endif
      OP_XOR:  r_simples = a ^ b;
      OP_NAND: r_simples = ~(a & b);
      OP_NOR:  r_simples = ~(a | b);
      default: r_simples = '0;
    endcase
  end

  // ---------------- registered results ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      done      <= 1'b0;
      resultado <= '0;
      zero      <= 1'b0;
      desvio    <= 1'b0;
      div_zero  <= 1'b0;
      erro      <= 1'b0;
      cnt       <= '0;
      b_reg     <= '0;
      mod_reg   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (aceita) begin
        cnt     <= '0;
        b_reg   <= b;
        mod_reg <= (controle == OP_MOD);
        if (!iterativo) begin
          done      <= 1'b1;
          resultado <= r_simples;
          zero      <= (r_simples == '0);
          desvio    <= d_simples;
          div_zero  <= 1'b0;
          erro      <= e_simples;
        end
      end else if (busy) begin
        cnt <= cnt + CW'(1);
        if (fim_iter) begin
          done      <= 1'b1;
          resultado <= r_iter;
          zero      <= (r_iter == '0);
          desvio    <= 1'b0;
          erro      <= 1'b0;
          div_zero  <= (estado == ST_DIV) && (b_reg == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb/tb_ula_multiciclo.sv - directed self-checking bench for ula_multiciclo

module tb_ula_multiciclo;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  controle;
  logic [31:0] a, b;
  logic        busy, done, zero, desvio, div_zero, erro;
  logic [31:0] resultado;

  int erros = 0;
  int total = 0;
  int lat, nbusy, ndone;

`ifdef MULT_FAST_EN
  localparam int LAT_MULT = 1;
`else
  localparam int LAT_MULT = 33;
`endif

  ula_multiciclo #(.LARGURA(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .controle  (controle),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .resultado (resultado),
    .zero      (zero),
    .desvio    (desvio),
    .div_zero  (div_zero),
    .erro      (erro)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      erros++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives start for exactly one rising edge (edge N),
  // returns at the negedge inside cycle N+1.
  task automatic emite(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y);
    controle = c;
    a        = x;
    b        = y;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  // Latency counts cycles from N+1 (=1) until done is seen.
  task automatic espera(output int l, output int nb);
    l  = 1;
    nb = 0;
    while (!done && l < 100) begin
      if (busy) nb++;
      @(negedge clock);
      l++;
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    controle = 5'd0;
    a        = 32'd0;
    b        = 32'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    verifica("reset_flags", {26'd0, busy, done, zero, desvio, div_zero, erro}, 32'd0);
    verifica("reset_result", resultado, 32'd0);

    // add wraps to zero
    emite(5'd0, 32'hFFFF_FFFF, 32'd1);
    espera(lat, nbusy);
    verifica("add_lat", lat, 32'd1);
    verifica("add_busy", nbusy, 32'd0);
    verifica("add_res", resultado, 32'd0);
    verifica("add_zero", zero, 1'b1);

    // signed branch compares
    emite(5'd18, 32'hFFFF_FFFE, 32'd3);
    espera(lat, nbusy);
    verifica("blt_desvio", desvio, 1'b1);
    verifica("blt_res", resultado, 32'hFFFF_FFFB);
    verifica("blt_zero", zero, 1'b0);
    emite(5'd19, 32'hFFFF_FFFE, 32'd3);
    espera(lat, nbusy);
    verifica("bgrt_desvio", desvio, 1'b0);
    verifica("bgrt_res", resultado, 32'hFFFF_FFFB);

    emite(5'd10, 32'hFFFF_FFFF, 32'd1);
    espera(lat, nbusy);
    verifica("slt_res", resultado, 32'd1);
    verifica("slt_desvio", desvio, 1'b0);
    emite(5'd11, 32'hFFFF_FFFF, 32'd1);
    espera(lat, nbusy);
    verifica("sgt_res", resultado, 32'd0);
    verifica("sgt_zero", zero, 1'b1);

    emite(5'd6, 32'h8000_0000, 32'd4);
    espera(lat, nbusy);
    verifica("shr_res", resultado, 32'h0800_0000);

    // div, then mod launched in the done cycle of the div
    emite(5'd13, 32'd100, 32'd7);
    espera(lat, nbusy);
    verifica("div_lat", lat, 32'd33);
    verifica("div_busy", nbusy, 32'd32);
    verifica("div_res", resultado, 32'd14);
    verifica("div_dz", div_zero, 1'b0);
    verifica("div_done_busy", busy, 1'b0);
    emite(5'd14, 32'd100, 32'd7);
    espera(lat, nbusy);
    verifica("mod_lat", lat, 32'd33);
    verifica("mod_res", resultado, 32'd2);

    // division by zero
    emite(5'd13, 32'd5, 32'd0);
    espera(lat, nbusy);
    verifica("div0_res", resultado, 32'hFFFF_FFFF);
    verifica("div0_dz", div_zero, 1'b1);
    emite(5'd14, 32'd5, 32'd0);
    espera(lat, nbusy);
    verifica("mod0_res", resultado, 32'd5);
    verifica("mod0_dz", div_zero, 1'b1);

    // mult with a second start pulsed mid-operation
    emite(5'd12, 32'd3, 32'd5);
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == 10) begin
        controle = 5'd0;
        a        = 32'd1;
        b        = 32'd1;
        start    = 1'b1;
      end else begin
        start    = 1'b0;
      end
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    verifica("mult_lat", lat, LAT_MULT);
    verifica("mult_res", resultado, 32'd15);
    verifica("mult_dz", div_zero, 1'b0);
    ndone = 0;
    repeat (5) begin
      @(negedge clock);
      if (done) ndone++;
    end
    verifica("mult_single_done", ndone, 32'd0);
    verifica("mult_held", resultado, 32'd15);

    // unsupported code, then flags clear on the next done
    emite(5'd25, 32'd7, 32'd9);
    espera(lat, nbusy);
    verifica("inv_lat", lat, 32'd1);
    verifica("inv_erro", erro, 1'b1);
    verifica("inv_res", resultado, 32'd0);
    verifica("inv_zero", zero, 1'b1);
    emite(5'd1, 32'd9, 32'd4);
    espera(lat, nbusy);
    verifica("sub_erro_clr", erro, 1'b0);
    verifica("sub_res", resultado, 32'd5);

    // reset in the middle of a division
    emite(5'd13, 32'd100, 32'd7);
    repeat (9) @(negedge clock);
    verifica("mid_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    verifica("rst_flags", {26'd0, busy, done, zero, desvio, div_zero, erro}, 32'd0);
    verifica("rst_res", resultado, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) ndone++;
    end
    verifica("rst_no_done", ndone, 32'd0);

    // divider still usable after the abort
    emite(5'd13, 32'd100, 32'd7);
    espera(lat, nbusy);
    verifica("div_after_rst", resultado, 32'd14);

    $display("Result: errors=%0d of %0d checks", erros, total);
    $finish;
  end

endmodule
